// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequencer slice.
// Opcode encoding is owned by the external ALU; the sequencer only forwards it.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [OP_W-1:0] ALU_SHR = 3'b101;
    localparam logic [OP_W-1:0] ALU_SHL = 3'b110;
    localparam logic [OP_W-1:0] ALU_NOT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction, ALU operand and result buses of the sequencer.
// master = sequencer side, slave = instruction source / ALU / consumer.
interface alu_sequencer_if #(
    parameter int NREGS = 4
);
    import alu_pkg::*;

    localparam int RA_W = $clog2(NREGS);

    logic              ins_valid;
    logic              ins_ready;
    logic [OP_W-1:0]   ins_op;
    logic [RA_W-1:0]   ins_rd;
    logic [RA_W-1:0]   ins_rs;
    logic [RA_W-1:0]   ins_rt;
    logic              ins_imm_en;
    logic [DATA_W-1:0] ins_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctl;
    logic [DATA_W-1:0] alu_ans;
    logic              alu_cout;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_cout;
    logic [RA_W-1:0]   res_rd;
    logic              carry_flag;

    modport master (
        input  ins_valid, ins_op, ins_rd, ins_rs, ins_rt,
        input  ins_imm_en, ins_imm,
        output ins_ready,
        output alu_a, alu_b, alu_ctl,
        input  alu_ans, alu_cout,
        output res_valid, res_data, res_cout, res_rd,
        input  res_ready,
        output carry_flag
    );

    modport slave (
        output ins_valid, ins_op, ins_rd, ins_rs, ins_rt,
        output ins_imm_en, ins_imm,
        input  ins_ready,
        input  alu_a, alu_b, alu_ctl,
        output alu_ans, alu_cout,
        input  res_valid, res_data, res_cout, res_rd,
        output res_ready,
        input  carry_flag
    );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: one synchronous write port,
// two asynchronous read ports, synchronous clear.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Issues one register/immediate instruction at a time to an external
// combinational ALU, captures its answer and writes it back.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 4
) (
    input logic             clk,
    input logic             rst,
    alu_sequencer_if.master bus
);

    localparam int RA_W = $clog2(NREGS);

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [OP_W-1:0]   alu_ctl_q,   alu_ctl_d;
    logic [RA_W-1:0]   rd_q,        rd_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;
    logic              res_cout_q,  res_cout_d;
    logic [RA_W-1:0]   res_rd_q,    res_rd_d;
    logic              carry_q,     carry_d;

    logic              rf_we;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    alu_regfile #(
        .NREGS (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (bus.alu_ans),
        .raddr_a (bus.ins_rs),
        .raddr_b (bus.ins_rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctl_d   = alu_ctl_q;
        rd_d        = rd_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        res_rd_d    = res_rd_q;
        carry_d     = carry_q;
        rf_we       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.ins_valid) begin
                    alu_a_d   = rf_a;
                    alu_b_d   = bus.ins_imm_en ? bus.ins_imm : rf_b;
                    alu_ctl_d = bus.ins_op;
                    rd_d      = bus.ins_rd;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU output settles during this cycle from the latched operands
                res_data_d  = bus.alu_ans;
                res_cout_d  = bus.alu_cout;
                res_rd_d    = rd_q;
                carry_d     = bus.alu_cout;
                res_valid_d = 1'b1;
                rf_we       = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctl_q   <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_rd_q    <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctl_q   <= alu_ctl_d;
            rd_q        <= rd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_rd_q    <= res_rd_d;
            carry_q     <= carry_d;
        end
    end

    assign bus.ins_ready  = (state_q == ST_IDLE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctl    = alu_ctl_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_cout   = res_cout_q;
    assign bus.res_rd     = res_rd_q;
    assign bus.carry_flag = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a
// latency/register-file scoreboard checked every cycle.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_sequencer_if #(.NREGS(4)) bus();

    alu_sequencer #(.NREGS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // {cout, ans} as the ALU defines them
    function automatic logic [4:0] alu_fn(input logic [2:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {1'b0, a} + {1'b0, ~b} + 5'd1;
            ALU_AND: return {1'b0, a & b};
            ALU_OR:  return {1'b0, a | b};
            ALU_XOR: return {1'b0, a ^ b};
            ALU_SHR: return {a[0], 1'b0, a[3:1]};
            ALU_SHL: return {a[3], a[2:0], 1'b0};
            default: return {1'b0, ~a};
        endcase
    endfunction

    always_comb begin
        {bus.alu_cout, bus.alu_ans} = alu_fn(bus.alu_ctl, bus.alu_a, bus.alu_b);
    end

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: architectural registers plus one in-flight instruction
    logic [3:0] m_regs [4] = '{default: 4'h0};
    logic       m_carry = 1'b0;
    bit         m_pend = 1'b0;
    int         m_age = 0;
    bit         m_res_valid = 1'b0;
    logic [3:0] m_alu_a = 4'h0, m_alu_b = 4'h0;
    logic [2:0] m_alu_ctl = 3'h0;
    logic [4:0] m_res = 5'h0;
    logic [1:0] m_rd = 2'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_regs      = '{default: 4'h0};
            m_carry     = 1'b0;
            m_pend      = 1'b0;
            m_res_valid = 1'b0;
            m_alu_a     = 4'h0;
            m_alu_b     = 4'h0;
            m_alu_ctl   = 3'h0;
        end else if (!m_pend) begin
            if (bus.ins_valid) begin
                m_alu_a   = m_regs[bus.ins_rs];
                m_alu_b   = bus.ins_imm_en ? bus.ins_imm : m_regs[bus.ins_rt];
                m_alu_ctl = bus.ins_op;
                m_rd      = bus.ins_rd;
                m_res     = alu_fn(m_alu_ctl, m_alu_a, m_alu_b);
                m_pend    = 1'b1;
                m_age     = 0;
            end
        end else if (m_age == 0) begin
            m_age        = 1;
            m_regs[m_rd] = m_res[3:0];
            m_carry      = m_res[4];
            m_res_valid  = 1'b1;
        end else if (bus.res_ready) begin
            m_pend      = 1'b0;
            m_res_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_ins_ready", bus.ins_ready, !m_pend);
            check("mon_res_valid", bus.res_valid, m_res_valid);
            check("mon_carry", bus.carry_flag, m_carry);
            check("mon_alu_a", bus.alu_a, m_alu_a);
            check("mon_alu_b", bus.alu_b, m_alu_b);
            check("mon_alu_ctl", bus.alu_ctl, m_alu_ctl);
            if (m_res_valid) begin
                check("mon_res_data", bus.res_data, m_res[3:0]);
                check("mon_res_cout", bus.res_cout, m_res[4]);
                check("mon_res_rd", bus.res_rd, m_rd);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [1:0] rt,
                         input logic ie, input logic [3:0] imm);
        bus.ins_op     = op;
        bus.ins_rd     = rd;
        bus.ins_rs     = rs;
        bus.ins_rt     = rt;
        bus.ins_imm_en = ie;
        bus.ins_imm    = imm;
    endtask

    task automatic wait_res(output int n);
        n = 1;
        while (!bus.res_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Full transaction with res_ready high; literal result checks
    task automatic issue(input string nm, input logic [2:0] op,
                         input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic ie,
                         input logic [3:0] imm, input logic [3:0] ed,
                         input logic ec);
        int n;
        @(negedge clk);
        check({nm, "_ready"}, bus.ins_ready, 1'b1);
        drive(op, rd, rs, rt, ie, imm);
        bus.ins_valid = 1'b1;
        @(posedge clk); #1;
        bus.ins_valid = 1'b0;
        drive(3'h7, 2'h3, 2'h3, 2'h3, 1'b1, 4'hF);
        wait_res(n);
        check({nm, "_latency_edges"}, 8'(n), 8'd2);
        check({nm, "_data"}, bus.res_data, ed);
        check({nm, "_cout"}, bus.res_cout, ec);
        check({nm, "_rd"}, bus.res_rd, rd);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.ins_valid = 1'b0;
        bus.res_ready = 1'b1;
        drive(3'h0, 2'h0, 2'h0, 2'h0, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ins_ready", bus.ins_ready, 1'b1);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_carry", bus.carry_flag, 1'b0);
        check("rst_alu_a", bus.alu_a, 4'h0);
        check("rst_alu_b", bus.alu_b, 4'h0);
        check("rst_alu_ctl", bus.alu_ctl, 3'h0);
        mon_en = 1'b1;

        issue("add_r0", ALU_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0);
        issue("sub_r1", ALU_SUB, 2'd1, 2'd1, 2'd1, 1'b0, 4'h0, 4'h0, 1'b1);
        issue("add_r1_9", ALU_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 4'h9, 4'h9, 1'b0);
        issue("add_r2_9", ALU_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'h9, 4'h2, 1'b1);
        check("add_r2_carry_flag", bus.carry_flag, 1'b1);
        issue("ld_r1_3", ALU_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'h3, 4'h3, 1'b0);
        issue("sub_r3_5", ALU_SUB, 2'd3, 2'd1, 2'd0, 1'b1, 4'h5, 4'hE, 1'b0);
        issue("ld_r1_b", ALU_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'hB, 4'hB, 1'b0);
        issue("shl", ALU_SHL, 2'd2, 2'd1, 2'd0, 1'b0, 4'h0, 4'h6, 1'b1);
        check("shl_alu_ctl", bus.alu_ctl, 3'b110);
        issue("shr", ALU_SHR, 2'd2, 2'd1, 2'd0, 1'b0, 4'h0, 4'h5, 1'b1);
        issue("not", ALU_NOT, 2'd2, 2'd1, 2'd0, 1'b0, 4'h0, 4'h4, 1'b0);

        // Backpressure with a second instruction held on the input
        bus.res_ready = 1'b0;
        @(negedge clk);
        drive(ALU_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 4'h8);
        bus.ins_valid = 1'b1;
        @(posedge clk); #1;
        drive(ALU_XOR, 2'd1, 2'd1, 2'd0, 1'b1, 4'hF);
        wait_res(n);
        check("bp_latency_edges", 8'(n), 8'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", bus.res_valid, 1'b1);
            check("bp_hold_data", bus.res_data, 4'h3);
            check("bp_hold_cout", bus.res_cout, 1'b1);
            check("bp_hold_ready", bus.ins_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", bus.ins_ready, 1'b1);
        check("bp_idle_valid", bus.res_valid, 1'b0);
        @(posedge clk); #1;
        bus.ins_valid = 1'b0;
        check("bp_second_accept", bus.ins_ready, 1'b0);
        wait_res(n);
        check("bp_second_data", bus.res_data, 4'h4);
        check("bp_second_cout", bus.res_cout, 1'b0);
        @(posedge clk); #1;
        issue("set_carry", ALU_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'hF, 4'h3, 1'b1);

        // Reset while the instruction is in EXEC
        @(negedge clk);
        drive(ALU_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 4'h7);
        bus.ins_valid = 1'b1;
        @(posedge clk); #1;
        bus.ins_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rexec_ins_ready", bus.ins_ready, 1'b1);
        check("rexec_res_valid", bus.res_valid, 1'b0);
        check("rexec_carry", bus.carry_flag, 1'b0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid) n++;
        end
        check("rexec_no_result", 8'(n), 8'd0);
        issue("rexec_r3", ALU_ADD, 2'd0, 2'd3, 2'd0, 1'b1, 4'h0, 4'h0, 1'b0);
        issue("rexec_r2", ALU_ADD, 2'd0, 2'd2, 2'd0, 1'b1, 4'h1, 4'h1, 1'b0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
